// File: rtl/rice_core_operand_fetch.sv
// Operand fetch: reads rs1/rs2 with write-back bypass and stalls on RAW hazards via per-register pending-write counters.
// Latency: 1 cycle from accept to o_of_valid through a single registered output stage.
// Backpressure: o_id_ready drops while the output stage is held, on source/overflow hazards, and during flush.
module rice_core_operand_fetch #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_id_valid,
    output logic                 o_id_ready,
    input  logic [4:0]           i_id_rs1,
    input  logic [4:0]           i_id_rs2,
    input  logic [4:0]           i_id_rd,
    input  logic                 i_id_rd_we,
    input  logic [32*XLEN-1:0]   i_rf_value,
    input  logic                 i_wb_valid,
    input  logic [4:0]           i_wb_rd,
    input  logic [XLEN-1:0]      i_wb_value,
    input  logic                 i_flush,
    output logic                 o_of_valid,
    input  logic                 i_of_ready,
    output logic [XLEN-1:0]      o_of_rs1_value,
    output logic [XLEN-1:0]      o_of_rs2_value,
    output logic [4:0]           o_of_rd,
    output logic                 o_of_rd_we
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_TWO = PEND_W'(2);

    logic [PEND_W-1:0] pend     [32];
    logic [PEND_W-1:0] pend_nxt [32];

    logic [PEND_W-1:0] rs1_pend;
    logic [PEND_W-1:0] rs2_pend;
    logic [PEND_W-1:0] rd_pend;
    logic              rs1_haz;
    logic              rs2_haz;
    logic              rd_full;
    logic              hazard;
    logic              accept;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [31:0]       inc_vec;
    logic [31:0]       wb_vec;
    logic [31:0]       fl_vec;

    function automatic logic [XLEN-1:0] fetch_operand(
        input logic [4:0]         rs,
        input logic [32*XLEN-1:0] rf,
        input logic               wb_vld,
        input logic [4:0]         wb_rd,
        input logic [XLEN-1:0]    wb_dat
    );
        if (rs == 5'd0) begin
            return '0;
        end
        if (wb_vld && (wb_rd == rs)) begin
            return wb_dat;
        end
        return rf[rs*XLEN +: XLEN];
    endfunction

    assign rs1_val = fetch_operand(i_id_rs1, i_rf_value, i_wb_valid, i_wb_rd, i_wb_value);
    assign rs2_val = fetch_operand(i_id_rs2, i_rf_value, i_wb_valid, i_wb_rd, i_wb_value);

    assign rs1_pend = pend[i_id_rs1];
    assign rs2_pend = pend[i_id_rs2];
    assign rd_pend  = pend[i_id_rd];

    // A single outstanding write that retires this cycle is satisfied by the bypass path.
    assign rs1_haz = (i_id_rs1 != 5'd0) && (rs1_pend != '0) &&
                     !((rs1_pend == PEND_ONE) && i_wb_valid && (i_wb_rd == i_id_rs1));
    assign rs2_haz = (i_id_rs2 != 5'd0) && (rs2_pend != '0) &&
                     !((rs2_pend == PEND_ONE) && i_wb_valid && (i_wb_rd == i_id_rs2));
    assign rd_full = i_id_rd_we && (i_id_rd != 5'd0) && (rd_pend == PEND_MAX);
    assign hazard  = rs1_haz || rs2_haz || rd_full;

    assign o_id_ready = (!o_of_valid || i_of_ready) && !hazard && !i_flush;
    assign accept     = i_id_valid && o_id_ready;

    always_comb begin
        inc_vec = '0;
        wb_vec  = '0;
        fl_vec  = '0;
        if (accept && i_id_rd_we) begin
            inc_vec[i_id_rd] = 1'b1;
        end
        if (i_wb_valid) begin
            wb_vec[i_wb_rd] = 1'b1;
        end
        if (i_flush && o_of_valid && o_of_rd_we) begin
            fl_vec[o_of_rd] = 1'b1;
        end
    end

    // Net change per register applied in one step, saturating at zero.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pend_nxt[r] = pend[r];
            case ({inc_vec[r], wb_vec[r], fl_vec[r]})
                3'b100:                 pend_nxt[r] = pend[r] + PEND_ONE;
                3'b010, 3'b001, 3'b111: pend_nxt[r] = (pend[r] != '0) ? pend[r] - PEND_ONE : '0;
                3'b011:                 pend_nxt[r] = (pend[r] > PEND_ONE) ? pend[r] - PEND_TWO : '0;
                default:                pend_nxt[r] = pend[r];
            endcase
        end
        pend_nxt[0] = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 32; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                pend[r] <= pend_nxt[r];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_of_valid     <= 1'b0;
            o_of_rs1_value <= '0;
            o_of_rs2_value <= '0;
            o_of_rd        <= '0;
            o_of_rd_we     <= 1'b0;
        end else if (i_flush) begin
            o_of_valid <= 1'b0;
        end else if (accept) begin
            o_of_valid     <= 1'b1;
            o_of_rs1_value <= rs1_val;
            o_of_rs2_value <= rs2_val;
            o_of_rd        <= i_id_rd;
            o_of_rd_we     <= i_id_rd_we && (i_id_rd != 5'd0);
        end else if (i_of_ready) begin
            o_of_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rice_core_operand_fetch.sv
// Randomized scoreboard bench for rice_core_operand_fetch against a register-level model of pending writes.
`timescale 1ns/1ps
module tb_rice_core_operand_fetch;

    localparam int XLEN   = 32;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_id_valid;
    logic                 o_id_ready;
    logic [4:0]           i_id_rs1;
    logic [4:0]           i_id_rs2;
    logic [4:0]           i_id_rd;
    logic                 i_id_rd_we;
    logic [32*XLEN-1:0]   i_rf_value;
    logic                 i_wb_valid;
    logic [4:0]           i_wb_rd;
    logic [XLEN-1:0]      i_wb_value;
    logic                 i_flush;
    logic                 o_of_valid;
    logic                 i_of_ready;
    logic [XLEN-1:0]      o_of_rs1_value;
    logic [XLEN-1:0]      o_of_rs2_value;
    logic [4:0]           o_of_rd;
    logic                 o_of_rd_we;

    always #5 i_clk = ~i_clk;

    rice_core_operand_fetch #(.XLEN(XLEN), .PEND_W(PEND_W)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_id_valid     (i_id_valid),
        .o_id_ready     (o_id_ready),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_rd        (i_id_rd),
        .i_id_rd_we     (i_id_rd_we),
        .i_rf_value     (i_rf_value),
        .i_wb_valid     (i_wb_valid),
        .i_wb_rd        (i_wb_rd),
        .i_wb_value     (i_wb_value),
        .i_flush        (i_flush),
        .o_of_valid     (o_of_valid),
        .i_of_ready     (i_of_ready),
        .o_of_rs1_value (o_of_rs1_value),
        .o_of_rs2_value (o_of_rs2_value),
        .o_of_rd        (o_of_rd),
        .o_of_rd_we     (o_of_rd_we)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t        q[$];
    exp_t        staged;
    bit          staged_vld;
    int          checks = 0;
    int          errors = 0;

    // Architectural view kept by the bench: register contents and in-flight write counts.
    logic [31:0] rf [32];
    int          pend [32];
    bit          st_vld;
    int          st_rd;
    bit          st_we;
    bit          wb_prev;
    logic [4:0]  wb_prev_rd;
    logic [31:0] wb_prev_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_operand(input int rs);
        if (rs == 0) return 32'd0;
        if (i_wb_valid && int'(i_wb_rd) == rs) return i_wb_value;
        return rf[rs];
    endfunction

    function automatic bit src_stall(input int rs);
        if (rs == 0 || pend[rs] == 0) return 1'b0;
        if (pend[rs] == 1 && i_wb_valid && int'(i_wb_rd) == rs) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        q.delete();
        staged_vld  = 1'b0;
        st_vld      = 1'b0;
        st_rd       = 0;
        st_we       = 1'b0;
        wb_prev     = 1'b0;
        wb_prev_rd  = '0;
        wb_prev_val = '0;
        for (int r = 0; r < 32; r++) pend[r] = 0;
    endtask

    task automatic drive_rf();
        for (int r = 0; r < 32; r++) i_rf_value[r*32 +: 32] = rf[r];
    endtask

    task automatic idle_inputs();
        i_id_valid = 1'b0;
        i_id_rs1   = '0;
        i_id_rs2   = '0;
        i_id_rd    = '0;
        i_id_rd_we = 1'b0;
        i_wb_valid = 1'b0;
        i_wb_rd    = '0;
        i_wb_value = '0;
        i_flush    = 1'b0;
        i_of_ready = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_of_valid", {31'd0, o_of_valid}, 32'd0);
        check("rst_rs1",      o_of_rs1_value, 32'd0);
        check("rst_rs2",      o_of_rs2_value, 32'd0);
        check("rst_rd",       {27'd0, o_of_rd}, 32'd0);
        check("rst_rd_we",    {31'd0, o_of_rd_we}, 32'd0);
    endtask

    // Called just after a rising edge: retire last cycle's effects, drive new stimulus, predict.
    task automatic drive_cycle(input int reg_span, input int wb_pct, input int flush_pct);
        int  live[$];
        int  rs1, rs2, rd;
        int  net [32];
        bit  haz, exp_ready, acc, we_eff;
        if (staged_vld) begin
            q.push_back(staged);
            staged_vld = 1'b0;
        end
        if (wb_prev && wb_prev_rd != 5'd0) rf[wb_prev_rd] = wb_prev_val;
        drive_rf();

        i_id_valid = ($urandom_range(99) < 80);
        i_id_rs1   = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(reg_span));
        i_id_rs2   = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(reg_span));
        i_id_rd    = 5'($urandom_range(reg_span));
        i_id_rd_we = ($urandom_range(9) < 7);
        i_of_ready = ($urandom_range(9) < 7);
        i_flush    = ($urandom_range(99) < flush_pct);
        i_wb_valid = ($urandom_range(99) < wb_pct);
        i_wb_value = $urandom;
        for (int r = 1; r < 32; r++) if (pend[r] > 0) live.push_back(r);
        if (live.size() != 0 && $urandom_range(9) < 8)
            i_wb_rd = 5'(live[$urandom_range(live.size() - 1)]);
        else
            i_wb_rd = 5'($urandom_range(31));

        #1;
        rs1 = int'(i_id_rs1);
        rs2 = int'(i_id_rs2);
        rd  = int'(i_id_rd);
        haz = src_stall(rs1) || src_stall(rs2) || (i_id_rd_we && rd != 0 && pend[rd] == PMAX);
        exp_ready = (!st_vld || i_of_ready) && !haz && !i_flush;
        check("id_ready", {31'd0, o_id_ready}, {31'd0, exp_ready});
        acc    = i_id_valid && exp_ready;
        we_eff = i_id_rd_we && rd != 0;
        if (acc) begin
            staged.rs1 = model_operand(rs1);
            staged.rs2 = model_operand(rs2);
            staged.rd  = i_id_rd;
            staged.we  = we_eff;
            staged_vld = 1'b1;
        end

        for (int r = 0; r < 32; r++) net[r] = 0;
        if (acc && we_eff) net[rd]++;
        if (i_wb_valid && i_wb_rd != 5'd0) net[int'(i_wb_rd)]--;
        if (i_flush && st_vld && st_we) net[st_rd]--;
        for (int r = 1; r < 32; r++) pend[r] = (pend[r] + net[r] < 0) ? 0 : pend[r] + net[r];

        if (i_flush) st_vld = 1'b0;
        else if (acc) begin
            st_vld = 1'b1;
            st_rd  = rd;
            st_we  = we_eff;
        end else if (i_of_ready) st_vld = 1'b0;

        wb_prev     = i_wb_valid;
        wb_prev_rd  = i_wb_rd;
        wb_prev_val = i_wb_value;
    endtask

    // Monitor: the queue head is whatever the output stage should be showing this cycle.
    initial begin
        forever begin
            @(negedge i_clk);
            check("of_valid", {31'd0, o_of_valid}, {31'd0, (q.size() != 0)});
            if (q.size() != 0) begin
                check("of_rs1", o_of_rs1_value, q[0].rs1);
                check("of_rs2", o_of_rs2_value, q[0].rs2);
                check("of_rd",  {27'd0, o_of_rd}, {27'd0, q[0].rd});
                check("of_we",  {31'd0, o_of_rd_we}, {31'd0, q[0].we});
                if (i_flush || i_of_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        idle_inputs();
        for (int r = 0; r < 32; r++) rf[r] = 32'hFFFF_FFFF;
        drive_rf();
        model_clear();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs();
        for (int r = 1; r < 32; r++) rf[r] = $urandom;
        drive_rf();
        i_rst_n = 1'b1;

        // Moderate write-back rate over a small register window: frequent RAW stalls and bypasses.
        for (int c = 0; c < 1500; c++) begin
            @(posedge i_clk);
            #1;
            drive_cycle(7, 40, 8);
        end

        // Drop reset in the middle of traffic; nothing may survive it.
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        idle_inputs();
        model_clear();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs();
        check("rst_id_ready", {31'd0, o_id_ready}, 32'd1);
        i_rst_n = 1'b1;

        // Few write-backs over four registers: counters reach saturation and overflow stalls.
        for (int c = 0; c < 1500; c++) begin
            @(posedge i_clk);
            #1;
            drive_cycle(3, 12, 5);
        end

        @(posedge i_clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
